// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg
// Shared definitions for the song player: the default voice count and age
// width, the note/duration/metadata field widths, and the allocator state
// encoding. The song reader and note_player import this too, so widths only
// change in one place.
package voice_allocator_pkg;

    localparam int NUM_VOICES_DEF = 3;
    localparam int AGE_W_DEF      = 4;
    localparam int NOTE_W         = 6;
    localparam int DUR_W          = 6;
    localparam int META_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSED = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/voice_allocator_voice_slot.sv
// voice_allocator_voice_slot (the "voice_slot")
// Holds the state of one note_player voice: the occupancy flag, the age
// counter used for voice stealing, and the registered note payload.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   load_i              this voice is assigned the incoming note this cycle
//   clear_i             voice_done from the note_player
//   age_tick_i          some voice is being assigned this cycle (ages advance)
//   note_i/duration_i/meta_i   incoming payload
//   busy_o, age_o       occupancy and age
//   note_o/duration_o/meta_o   held payload
module voice_allocator_voice_slot
    import voice_allocator_pkg::*;
#(
    parameter int AGE_W = AGE_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              age_tick_i,
    input  logic [NOTE_W-1:0] note_i,
    input  logic [DUR_W-1:0]  duration_i,
    input  logic [META_W-1:0] meta_i,
    output logic              busy_o,
    output logic [AGE_W-1:0]  age_o,
    output logic [NOTE_W-1:0] note_o,
    output logic [DUR_W-1:0]  duration_o,
    output logic [META_W-1:0] meta_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic              busy_q, busy_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [META_W-1:0] meta_q, meta_d;

    // A load wins over a coincident done, so a voice re-assigned in the same
    // cycle it finishes stays busy. Only voices still busy after this cycle's
    // done age; a voice that just finished or sits idle keeps its age.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        note_d = note_q;
        dur_d  = dur_q;
        meta_d = meta_q;
        if (clear_i) begin
            busy_d = 1'b0;
        end
        if (load_i) begin
            busy_d = 1'b1;
            age_d  = '0;
            note_d = note_i;
            dur_d  = duration_i;
            meta_d = meta_i;
        end else if (age_tick_i && busy_q && !clear_i && (age_q != AGE_MAX)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= 1'b0;
            age_q  <= '0;
            note_q <= '0;
            dur_q  <= '0;
            meta_q <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            note_q <= note_d;
            dur_q  <= dur_d;
            meta_q <= meta_d;
        end
    end

    assign busy_o     = busy_q;
    assign age_o      = age_q;
    assign note_o     = note_q;
    assign duration_o = dur_q;
    assign meta_o     = meta_q;

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Hands notes from the song reader to a pool of note_player voices. A new note
// goes to the lowest free voice, or steals the oldest busy voice when none is
// free. Notes arriving while paused are dropped.
// Ports:
//   clk_i, reset_i                    clock, asynchronous active-high reset
//   play_i                            1 = song running, 0 = paused
//   new_note_i, note_i, duration_i, metadata_i   incoming note (one-cycle pulse)
//   voice_done_i                      per-voice "note finished" pulses
//   voice_start_o                     one-hot load pulse, one cycle after new_note
//   voice_note_o/voice_duration_o/voice_meta_o   per-voice packed payloads
//   busy_o, all_idle_o                per-voice occupancy, and "nothing busy"
//   stolen_o, dropped_o               pulses flagging a steal / a dropped note
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         play_i,
    input  logic                         new_note_i,
    input  logic [NOTE_W-1:0]            note_i,
    input  logic [DUR_W-1:0]             duration_i,
    input  logic [META_W-1:0]            metadata_i,
    input  logic [NUM_VOICES-1:0]        voice_done_i,
    output logic [NUM_VOICES-1:0]        voice_start_o,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note_o,
    output logic [DUR_W*NUM_VOICES-1:0]  voice_duration_o,
    output logic [META_W*NUM_VOICES-1:0] voice_meta_o,
    output logic [NUM_VOICES-1:0]        busy_o,
    output logic                         stolen_o,
    output logic                         dropped_o,
    output logic                         all_idle_o
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    alloc_state_e          state_q, state_d;
    logic [NUM_VOICES-1:0] voice_start_q;
    logic                  stolen_q, dropped_q;

    logic [NUM_VOICES-1:0] busy;
    logic [NUM_VOICES-1:0] busy_avail;
    logic [NUM_VOICES-1:0] busy_next;
    logic [NUM_VOICES-1:0] load;
    logic [AGE_W-1:0]      age [NUM_VOICES];
    logic                  accept;
    logic                  any_free;
    logic [IDX_W-1:0]      sel;
    logic [AGE_W-1:0]      best_age;

    // Done is applied before selection, so a voice finishing this cycle is
    // already free for the incoming note.
    assign accept     = new_note_i && (state_q != ST_PAUSED);
    assign busy_avail = busy & ~voice_done_i;

    // Lowest free voice, scanning downward so the lowest index is written last.
    // With no free voice, strict '>' keeps the lowest index on an age tie.
    always_comb begin
        any_free = 1'b0;
        sel      = '0;
        best_age = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!busy_avail[i]) begin
                any_free = 1'b1;
                sel      = IDX_W'(i);
            end
        end
        if (!any_free) begin
            sel      = '0;
            best_age = age[0];
            for (int i = 1; i < NUM_VOICES; i++) begin
                if (age[i] > best_age) begin
                    best_age = age[i];
                    sel      = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            load[i] = accept && (sel == IDX_W'(i));
        end
    end

    assign busy_next = busy_avail | load;

    // IDLE vs ACTIVE follows the occupancy the voices will have next cycle,
    // so the last voice clearing without a new note falls back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (!play_i)         state_d = ST_PAUSED;
                else if (|busy_next) state_d = ST_ACTIVE;
                else                 state_d = ST_IDLE;
            end
            ST_PAUSED: begin
                if (play_i) state_d = (|busy_next) ? ST_ACTIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            voice_start_q <= '0;
            stolen_q      <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            voice_start_q <= load;
            stolen_q      <= accept && !any_free;
            dropped_q     <= new_note_i && (state_q == ST_PAUSED);
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_allocator_voice_slot #(
            .AGE_W(AGE_W)
        ) u_slot (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .load_i     (load[g]),
            .clear_i    (voice_done_i[g]),
            .age_tick_i (accept),
            .note_i     (note_i),
            .duration_i (duration_i),
            .meta_i     (metadata_i),
            .busy_o     (busy[g]),
            .age_o      (age[g]),
            .note_o     (voice_note_o[g*NOTE_W +: NOTE_W]),
            .duration_o (voice_duration_o[g*DUR_W +: DUR_W]),
            .meta_o     (voice_meta_o[g*META_W +: META_W])
        );
    end

    assign voice_start_o = voice_start_q;
    assign stolen_o      = stolen_q;
    assign dropped_o     = dropped_q;
    assign busy_o        = busy;
    assign all_idle_o    = ~|busy;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Drives voice_allocator with directed scenarios followed by random traffic.
// A behavioural model of the voice pool predicts each start/drop response and
// queues it; a monitor pops and compares whenever the DUT presents one.
module tb_voice_allocator;

    localparam int NV      = 3;
    localparam int AGE_MAX = 15;

    typedef struct {
        logic [NV-1:0] start;
        logic          stolen;
        logic          dropped;
        int            idx;
        logic [5:0]    note;
        logic [5:0]    dur;
        logic [2:0]    meta;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            play;
    logic            newNote;
    logic [5:0]      note;
    logic [5:0]      duration;
    logic [2:0]      metadata;
    logic [NV-1:0]   voiceDone;
    logic [NV-1:0]   voiceStart;
    logic [6*NV-1:0] voiceNote;
    logic [6*NV-1:0] voiceDuration;
    logic [3*NV-1:0] voiceMeta;
    logic [NV-1:0]   busy;
    logic            stolen;
    logic            dropped;
    logic            allIdle;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    // Reference model of the voice pool
    bit   mBusy  [NV];
    int   mAge   [NV];
    bit   mPaused;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .play_i           (play),
        .new_note_i       (newNote),
        .note_i           (note),
        .duration_i       (duration),
        .metadata_i       (metadata),
        .voice_done_i     (voiceDone),
        .voice_start_o    (voiceStart),
        .voice_note_o     (voiceNote),
        .voice_duration_o (voiceDuration),
        .voice_meta_o     (voiceMeta),
        .busy_o           (busy),
        .stolen_o         (stolen),
        .dropped_o        (dropped),
        .all_idle_o       (allIdle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [NV-1:0] modelBusyVec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = mBusy[i];
        return v;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NV; i++) begin
            mBusy[i] = 1'b0;
            mAge[i]  = 0;
        end
        mPaused = 1'b0;
        expQ.delete();
    endfunction

    // One clock of the pool: finished voices leave first, then the note takes
    // the lowest free voice or the oldest busy one; the next cycle is paused
    // exactly when play is low now.
    function automatic void modelStep(bit pl, bit nn, logic [5:0] n, logic [5:0] d,
                                      logic [2:0] m, logic [NV-1:0] done);
        exp_t e;
        int   chosen;
        bit   found;
        for (int i = 0; i < NV; i++) if (done[i]) mBusy[i] = 1'b0;
        if (nn && !mPaused) begin
            found  = 1'b0;
            chosen = 0;
            for (int i = 0; i < NV; i++) begin
                if (!found && !mBusy[i]) begin
                    found  = 1'b1;
                    chosen = i;
                end
            end
            if (!found) begin
                for (int i = 1; i < NV; i++) if (mAge[i] > mAge[chosen]) chosen = i;
            end
            for (int i = 0; i < NV; i++) begin
                if (i != chosen && mBusy[i] && mAge[i] < AGE_MAX) mAge[i]++;
            end
            mBusy[chosen] = 1'b1;
            mAge[chosen]  = 0;
            e.start         = '0;
            e.start[chosen] = 1'b1;
            e.stolen  = !found;
            e.dropped = 1'b0;
            e.idx     = chosen;
            e.note    = n;
            e.dur     = d;
            e.meta    = m;
            expQ.push_back(e);
        end else if (nn) begin
            e.start   = '0;
            e.stolen  = 1'b0;
            e.dropped = 1'b1;
            e.idx     = 0;
            e.note    = '0;
            e.dur     = '0;
            e.meta    = '0;
            expQ.push_back(e);
        end
        mPaused = !pl;
    endfunction

    // Monitor: pops an expectation whenever the DUT reports a start or a drop.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (voiceStart != '0 || stolen || dropped)) begin
                if (expQ.size() == 0) begin
                    compare("unexpected_output", {voiceStart, stolen, dropped}, '0);
                end else begin
                    e = expQ.pop_front();
                    compare("voice_start", voiceStart, e.start);
                    compare("stolen", stolen, e.stolen);
                    compare("dropped", dropped, e.dropped);
                    if (e.start != '0) begin
                        compare("voice_note", voiceNote[e.idx*6 +: 6], e.note);
                        compare("voice_duration", voiceDuration[e.idx*6 +: 6], e.dur);
                        compare("voice_meta", voiceMeta[e.idx*3 +: 3], e.meta);
                    end
                end
            end
        end
    end

    task automatic checkOutput(string tag);
        compare({tag, "_busy"}, busy, modelBusyVec());
        compare({tag, "_all_idle"}, allIdle, (modelBusyVec() == '0));
    endtask

    task automatic applyStimulus(bit pl, bit nn, logic [5:0] n, logic [5:0] d,
                                 logic [2:0] m, logic [NV-1:0] done, string tag);
        @(negedge clk);
        play      = pl;
        newNote   = nn;
        note      = n;
        duration  = d;
        metadata  = m;
        voiceDone = done;
        modelStep(pl, nn, n, d, m, done);
        @(posedge clk);
        #2;
        checkOutput(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        newNote   = 1'b0;
        voiceDone = '0;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        compare("reset_busy", busy, '0);
        compare("reset_all_idle", allIdle, 1'b1);
        compare("reset_start", voiceStart, '0);
        compare("reset_pulses", {stolen, dropped}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        play      = 1'b1;
        newNote   = 1'b0;
        note      = '0;
        duration  = '0;
        metadata  = '0;
        voiceDone = '0;
        modelReset();
        repeat (2) @(posedge clk);
        doReset();

        // Three notes fill the voices in index order
        applyStimulus(1, 1, 6'd10, 6'd4, 3'd1, 3'b000, "fill0");
        applyStimulus(1, 1, 6'd11, 6'd0, 3'd2, 3'b000, "fill1");
        applyStimulus(1, 1, 6'd12, 6'd9, 3'd3, 3'b000, "fill2");

        // All busy: voice 0 is oldest and is stolen
        applyStimulus(1, 1, 6'd20, 6'd5, 3'd7, 3'b000, "steal");
        compare("age0_after_steal", dut.g_slot[0].u_slot.age_o, mAge[0]);
        compare("age1_after_steal", dut.g_slot[1].u_slot.age_o, mAge[1]);

        // Done and new note together: the finishing voice is reused, no steal
        applyStimulus(1, 1, 6'd33, 6'd2, 3'd4, 3'b010, "done_reuse");

        // Pause: note dropped, done still clears busy
        applyStimulus(0, 0, 6'd0,  6'd0, 3'd0, 3'b000, "pause");
        applyStimulus(0, 1, 6'd40, 6'd3, 3'd5, 3'b000, "drop");
        applyStimulus(0, 0, 6'd0,  6'd0, 3'd0, 3'b100, "pause_done");
        applyStimulus(1, 0, 6'd0,  6'd0, 3'd0, 3'b000, "resume");

        // Reach busy = 101, then reset asynchronously mid-song
        applyStimulus(1, 1, 6'd41, 6'd1, 3'd6, 3'b000, "refill");
        applyStimulus(1, 0, 6'd0,  6'd0, 3'd0, 3'b010, "make101");
        compare("busy_before_reset", busy, 3'b101);
        doReset();
        applyStimulus(1, 1, 6'd50, 6'd7, 3'd2, 3'b000, "after_reset");

        // Age saturation: voice 0 reassigned 20 times while voice 1 waits
        applyStimulus(1, 1, 6'd51, 6'd7, 3'd2, 3'b000, "sat_setup");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1, 6'(k), 6'(k + 1), 3'(k), 3'b001, "sat_loop");
        end
        compare("age1_saturated", dut.g_slot[1].u_slot.age_o, mAge[1]);
        compare("age1_is_max", dut.g_slot[1].u_slot.age_o, AGE_MAX);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [NV-1:0] d;
            for (int i = 0; i < NV; i++) d[i] = ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                          6'($urandom), 6'($urandom), 3'($urandom), d, "random");
        end

        applyStimulus(1, 0, 6'd0, 6'd0, 3'd0, 3'b000, "drain");
        repeat (2) @(posedge clk);
        #1;
        compare("pending_expectations", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter: NUM_VOICES, default 3, number of note_player voices shared; legal range 2..4.
REQ-002 Parameter: AGE_W, default 4, width of each voice age counter.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 play  in  1  1 = song running; 0 = paused.
REQ-006 new_note  in  1  one-cycle pulse from the song reader: note/duration/metadata valid.
REQ-007 note  in  6  note number; duration  in  6  length in beats; metadata  in  3  per-note flags.
REQ-008 voice_done  in  NUM_VOICES  per-voice pulse from note_player: note finished.
REQ-009 voice_start  out  NUM_VOICES  one-hot pulse that loads a note into a voice.
REQ-010 voice_note  out  6*NUM_VOICES; voice_duration  out  6*NUM_VOICES; voice_meta  out  3*NUM_VOICES; registered per-voice payloads.
REQ-011 busy  out  NUM_VOICES  per-voice occupancy.
REQ-012 stolen  out  1  pulse: an assignment pre-empted a busy voice.
REQ-013 dropped  out  1  pulse: new_note discarded while paused.
REQ-014 all_idle  out  1  high when busy is all zeros.

Function
REQ-015 FSM states: IDLE (no voice busy), ACTIVE (at least one voice busy), PAUSED (play = 0).
REQ-016 IDLE->PAUSED and ACTIVE->PAUSED when play = 0; PAUSED->ACTIVE when play = 1 and busy is non-zero, else PAUSED->IDLE.
REQ-017 IDLE->ACTIVE on an accepted new_note; ACTIVE->IDLE when the last busy voice clears with no new_note in the same cycle.
REQ-018 new_note is accepted only in IDLE or ACTIVE; in PAUSED it is dropped and dropped pulses one cycle later.
REQ-019 Free-voice selection: lowest-index voice with busy = 0.
REQ-020 With no free voice, the allocator steals the voice with the largest age; ties go to the lowest index; stolen pulses together with voice_start.
REQ-021 Latency: new_note in cycle t gives voice_start and the updated payload/busy in cycle t+1; throughput is one note per cycle.
REQ-022 A voice_done and new_note in the same cycle: done is applied first, so that voice counts as free for selection.
REQ-023 voice_done on a voice that is not busy is ignored; voice_done on the voice being assigned in the same cycle leaves it busy.
REQ-024 On assignment, the chosen voice's age resets to 0; the age of every other busy voice increments, saturating at 2^AGE_W-1; the age of idle voices holds.
REQ-025 voice_note, voice_duration and voice_meta hold their last values until the next assignment to that voice.
REQ-026 While PAUSED, busy, ages and payloads are frozen; voice_done is still honoured.
REQ-027 A duration of 0 is passed through unchanged; the allocator does not interpret duration or metadata.

Reset
REQ-028 Asynchronous reset forces state IDLE, and forces busy, ages, payloads, voice_start, stolen and dropped to 0; all_idle = 1.
REQ-029 Reset mid-note drops all voice ownership immediately; no voice_start is issued for a new_note coincident with reset.

Structure
REQ-030 The NUM_VOICES default, AGE_W default, note/duration/metadata widths and state encodings belong in a shared package used by the song reader and note_player.
REQ-031 One sub-module, voice_slot: the per-voice busy flag, age counter and payload registers, instantiated NUM_VOICES times; selection and FSM logic stay in the top.

Verification
REQ-032 After reset, three new_note pulses with notes 10, 11, 12 -> voice_start = 001, 010, 100 on consecutive cycles; busy = 111; stolen is never asserted.
REQ-033 All voices busy, voice 0 oldest, then new_note with note 20 -> voice_start = 001, stolen = 1, voice_note[0] = 20, age[0] = 0.
REQ-034 busy = 111, with voice_done = 010 and new_note in the same cycle -> voice_start = 010 and stolen = 0.
REQ-035 play = 0, then new_note -> dropped pulses, voice_start = 0, state PAUSED; a voice_done during the pause still clears busy.
REQ-036 Reset asserted mid-song with busy = 101 -> busy = 000 and all_idle = 1 asynchronously; the first new_note after reset goes to voice 0.
REQ-037 Ages saturation: 20 assignments to voice 0 while voice 1 stays busy -> age[1] saturates at 15 with no wrap.
